// File: rtl/mem_resp_pkg.sv
// Shared types for the memory write responder: status bits, FSM states, popcount.
// Imported by mem_write_responder and mem_wr_beat_tracker.
package mem_resp_pkg;

  localparam int STS_OKAY   = 7;
  localparam int STS_SLVERR = 6;
  localparam int STS_DECERR = 5;
  localparam int STS_INTERR = 4;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STATUS
  } fsm_t;

  // Wide enough for keep vectors of payloads up to 2048 bits.
  localparam int PC_W = 256;

  function automatic logic [15:0] popcount(
    input logic [PC_W-1:0] v
  );
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < PC_W; i++) begin
      c = c + 16'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/mem_wr_beat_tracker.sv
// Remaining-byte counter for one write command; flags INTERR on overrun or short last.
// Ports: load/len start a command, beat/nbytes/last per accepted beat, live/interr out.
module mem_wr_beat_tracker #(
  parameter int LEN_W = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  input  logic             beat,
  input  logic [LEN_W-1:0] nbytes,
  input  logic             last,
  output logic             live,
  output logic             interr
);

  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] rem_nxt;
  logic             over;

  // A beat arriving with nothing left, or carrying more than is left,
  // is an overrun; the counter saturates at zero.
  always_comb begin
    rem_nxt = rem;
    over    = 1'b0;
    if (rem == '0) begin
      over = 1'b1;
    end else if (nbytes > rem) begin
      rem_nxt = '0;
      over    = 1'b1;
    end else begin
      rem_nxt = rem - nbytes;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem    <= '0;
      interr <= 1'b0;
    end else if (load) begin
      rem    <= len;
      interr <= 1'b0;
    end else if (beat) begin
      rem <= rem_nxt;
      if (over || (last && rem_nxt != '0)) begin
        interr <= 1'b1;
      end
    end
  end

  assign live = (rem != '0);

endmodule

// File: rtl/mem_write_responder.sv
// Memory-side endpoint of the TCP write path: cmd+payload in, memory writes and one status out.
// Ports: s_cmd_*, s_data_*, m_sts_*, mem_* write port, cmd/last/sts debug counters.
module mem_write_responder
  import mem_resp_pkg::*;
#(
  parameter  int DATA_W     = 512,
  parameter  int MEM_BYTES  = 2**24,
  parameter  int LEN_W      = 23,
  localparam int KEEP_W     = DATA_W / 8,
  localparam int MEM_ADDR_W = $clog2(MEM_BYTES / KEEP_W)
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_cmd_valid,
  output logic                  s_cmd_ready,
  input  logic [63:0]           s_cmd_address,
  input  logic [LEN_W-1:0]      s_cmd_length,
  input  logic                  s_data_valid,
  output logic                  s_data_ready,
  input  logic [DATA_W-1:0]     s_data_data,
  input  logic [KEEP_W-1:0]     s_data_keep,
  input  logic                  s_data_last,
  output logic                  m_sts_valid,
  input  logic                  m_sts_ready,
  output logic [7:0]            m_sts_data,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [KEEP_W-1:0]     mem_wstrb,
  output logic [31:0]           cmd_cnt,
  output logic [31:0]           last_cnt,
  output logic [31:0]           sts_cnt
);

  localparam int OFF_W = $clog2(KEEP_W);

  fsm_t state;
  fsm_t state_nxt;

  logic                  cmd_hs;
  logic                  data_hs;
  logic                  sts_hs;
  logic                  decerr;
  logic                  interr;
  logic                  live;
  logic                  bad_cmd;
  logic [64:0]           end_addr;
  logic [LEN_W-1:0]      nbytes;
  logic [MEM_ADDR_W-1:0] start_beat;
  logic [MEM_ADDR_W-1:0] beat_idx;

  // Ready is forced low while reset is held so every output reads zero.
  assign s_cmd_ready  = aresetn && (state == IDLE);
  assign s_data_ready = (state == DATA);
  assign m_sts_valid  = (state == STATUS);

  assign cmd_hs  = s_cmd_valid && s_cmd_ready;
  assign data_hs = s_data_valid && s_data_ready;
  assign sts_hs  = m_sts_valid && m_sts_ready;

  // 65-bit end address so huge start addresses cannot wrap into range.
  assign end_addr = {1'b0, s_cmd_address} + 65'(s_cmd_length);
  assign bad_cmd  = (s_cmd_address[OFF_W-1:0] != '0)
                 || (end_addr > 65'(MEM_BYTES));

  assign nbytes = LEN_W'(popcount(PC_W'(s_data_keep)));

  mem_wr_beat_tracker #(
    .LEN_W (LEN_W)
  ) u_tracker (
    .clk    (aclk),
    .rst_n  (aresetn),
    .load   (cmd_hs),
    .len    (s_cmd_length),
    .beat   (data_hs),
    .nbytes (nbytes),
    .last   (s_data_last),
    .live   (live),
    .interr (interr)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cmd_hs) begin
          state_nxt = (s_cmd_length == '0) ? STATUS : DATA;
        end
      end
      DATA: begin
        if (data_hs && s_data_last) begin
          state_nxt = STATUS;
        end
      end
      STATUS: begin
        if (m_sts_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_sts_data = '0;
    if (state == STATUS) begin
      m_sts_data[STS_OKAY]   = ~(decerr | interr);
      m_sts_data[STS_SLVERR] = 1'b0;
      m_sts_data[STS_DECERR] = decerr;
      m_sts_data[STS_INTERR] = interr;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      decerr     <= 1'b0;
      start_beat <= '0;
      beat_idx   <= '0;
    end else begin
      state <= state_nxt;
      if (cmd_hs) begin
        decerr     <= (s_cmd_length != '0) && bad_cmd;
        start_beat <= s_cmd_address[OFF_W +: MEM_ADDR_W];
        beat_idx   <= '0;
      end else if (data_hs) begin
        beat_idx <= beat_idx + 1'b1;
      end
    end
  end

  // Beats past the command length are drained without touching memory.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      mem_we <= data_hs && live && !decerr;
      if (data_hs) begin
        mem_addr  <= start_beat + beat_idx;
        mem_wdata <= s_data_data;
        mem_wstrb <= decerr ? '0 : s_data_keep;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cmd_cnt  <= '0;
      last_cnt <= '0;
      sts_cnt  <= '0;
    end else begin
      if (cmd_hs) cmd_cnt <= cmd_cnt + 32'd1;
      if (data_hs && s_data_last) last_cnt <= last_cnt + 32'd1;
      if (sts_hs) sts_cnt <= sts_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_mem_write_responder.sv
// Self-checking bench for mem_write_responder: directed table, corner sequences, random vs model.
// Drives at posedge+2, samples at negedge.
module tb_mem_write_responder;

  localparam logic [64:0] MEMB = 65'd16777216;

  logic         clk;
  logic         aresetn;
  logic         s_cmd_valid;
  logic         s_cmd_ready;
  logic [63:0]  s_cmd_address;
  logic [22:0]  s_cmd_length;
  logic         s_data_valid;
  logic         s_data_ready;
  logic [511:0] s_data_data;
  logic [63:0]  s_data_keep;
  logic         s_data_last;
  logic         m_sts_valid;
  logic         m_sts_ready;
  logic [7:0]   m_sts_data;
  logic         mem_we;
  logic [17:0]  mem_addr;
  logic [511:0] mem_wdata;
  logic [63:0]  mem_wstrb;
  logic [31:0]  cmd_cnt;
  logic [31:0]  last_cnt;
  logic [31:0]  sts_cnt;

  mem_write_responder dut (
    .aclk          (clk),
    .aresetn       (aresetn),
    .s_cmd_valid   (s_cmd_valid),
    .s_cmd_ready   (s_cmd_ready),
    .s_cmd_address (s_cmd_address),
    .s_cmd_length  (s_cmd_length),
    .s_data_valid  (s_data_valid),
    .s_data_ready  (s_data_ready),
    .s_data_data   (s_data_data),
    .s_data_keep   (s_data_keep),
    .s_data_last   (s_data_last),
    .m_sts_valid   (m_sts_valid),
    .m_sts_ready   (m_sts_ready),
    .m_sts_data    (m_sts_data),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .cmd_cnt       (cmd_cnt),
    .last_cnt      (last_cnt),
    .sts_cnt       (sts_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [17:0]  wr_addr_q[$];
  logic [511:0] wr_data_q[$];
  logic [63:0]  wr_strb_q[$];
  logic [7:0]   sts_q[$];
  int           exp_widx[$];

  int           drv_nb[16];
  logic [511:0] drv_data[16];
  int           exp_cmd = 0;
  int           exp_last = 0;
  int           exp_sts = 0;

  always @(negedge clk) begin
    if (aresetn) begin
      if (mem_we) begin
        wr_addr_q.push_back(mem_addr);
        wr_data_q.push_back(mem_wdata);
        wr_strb_q.push_back(mem_wstrb);
      end
      if (m_sts_valid && m_sts_ready) sts_q.push_back(m_sts_data);
    end
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] kmask(input int n);
    logic [63:0] one;
    one = 64'd1;
    if (n >= 64) return '1;
    return (one << n) - 64'd1;
  endfunction

  function automatic logic [511:0] rnd_data();
    logic [511:0] d;
    for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic clear_q();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_strb_q.delete();
    sts_q.delete();
    exp_widx.delete();
  endtask

  task automatic send_cmd(input logic [63:0] a, input int len);
    bit ok;
    ok = 1'b0;
    s_cmd_valid   = 1'b1;
    s_cmd_address = a;
    s_cmd_length  = 23'(len);
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = s_cmd_ready;
    end
    @(posedge clk);
    #2;
    s_cmd_valid = 1'b0;
    check("cmd_handshake", 64'(ok), 64'd1);
  endtask

  task automatic send_beat(input logic [511:0] d, input logic [63:0] k,
                           input bit last);
    bit ok;
    ok = 1'b0;
    s_data_valid = 1'b1;
    s_data_data  = d;
    s_data_keep  = k;
    s_data_last  = last;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = s_data_ready;
    end
    @(posedge clk);
    #2;
    s_data_valid = 1'b0;
    s_data_last  = 1'b0;
    check("data_handshake", 64'(ok), 64'd1);
  endtask

  task automatic wait_sts();
    bit got;
    got = 1'b0;
    m_sts_ready = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      #1;
      got = (sts_q.size() > 0);
    end
    @(posedge clk);
    #2;
    check("sts_handshake", 64'(got), 64'd1);
  endtask

  task automatic run_txn(input logic [63:0] a, input int len,
                         input int nbeats, input bit gaps);
    send_cmd(a, len);
    exp_cmd++;
    for (int b = 0; b < nbeats; b++) begin
      if (gaps) begin
        repeat ($urandom % 3) begin
          @(posedge clk);
          #2;
        end
      end
      drv_data[b] = rnd_data();
      send_beat(drv_data[b], kmask(drv_nb[b]), b == nbeats - 1);
    end
    if (nbeats > 0) exp_last++;
    wait_sts();
    exp_sts++;
    repeat (2) @(posedge clk);
    #2;
  endtask

  // Written beats, addresses and data must match the expected beat list.
  task automatic compare(input string tag, input logic [7:0] ests,
                         input logic [17:0] base);
    check({tag, "_nsts"}, 64'(sts_q.size()), 64'd1);
    if (sts_q.size() > 0) check({tag, "_sts"}, 64'(sts_q[0]), 64'(ests));
    check({tag, "_nwr"}, 64'(wr_addr_q.size()), 64'(exp_widx.size()));
    for (int i = 0; i < exp_widx.size() && i < wr_addr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr_q[i]),
            64'(18'(base + 18'(exp_widx[i]))));
      check($sformatf("%s_data%0d", tag, i),
            64'(wr_data_q[i] == drv_data[exp_widx[i]]), 64'd1);
      check($sformatf("%s_strb%0d", tag, i), wr_strb_q[i],
            kmask(drv_nb[exp_widx[i]]));
    end
  endtask

  // Reference model: walk the beats and apply the byte-budget rules directly.
  task automatic model(input logic [63:0] a, input int len, input int nbeats,
                       output logic [7:0] sts);
    logic [64:0] endp;
    bit dec;
    bit ie;
    int rem;
    endp = {1'b0, a} + 65'(len);
    dec  = (len != 0) && ((a % 64) != 0 || endp > MEMB);
    ie   = 1'b0;
    rem  = len;
    exp_widx.delete();
    for (int b = 0; b < nbeats; b++) begin
      if (rem == 0) begin
        ie = 1'b1;
      end else begin
        if (!dec) exp_widx.push_back(b);
        if (drv_nb[b] > rem) begin
          ie  = 1'b1;
          rem = 0;
        end else begin
          rem = rem - drv_nb[b];
        end
      end
    end
    if (nbeats > 0 && rem != 0) ie = 1'b1;
    sts = 8'h00;
    if (!dec && !ie) sts = 8'h80;
    if (dec) sts = sts | 8'h20;
    if (ie) sts = sts | 8'h10;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_cmd_cnt"}, 64'(cmd_cnt), 64'(exp_cmd));
    check({tag, "_last_cnt"}, 64'(last_cnt), 64'(exp_last));
    check({tag, "_sts_cnt"}, 64'(sts_cnt), 64'(exp_sts));
  endtask

  typedef struct {
    logic [63:0] addr;
    int          len;
    int          nbeats;
    int          nb[4];
    logic [7:0]  sts;
    int          nw;
    logic [17:0] a0;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [7:0] msts;
    bit         stable;

    // Status is OKAY only when no error flag is raised.
    vt[0] = '{64'h0, 128, 2, '{64, 64, 0, 0}, 8'h80, 2, 18'd0};
    vt[1] = '{64'h40, 100, 2, '{64, 36, 0, 0}, 8'h80, 2, 18'd1};
    vt[2] = '{64'h0, 128, 1, '{64, 0, 0, 0}, 8'h10, 1, 18'd0};
    vt[3] = '{64'h0, 64, 2, '{64, 64, 0, 0}, 8'h10, 1, 18'd0};
    vt[4] = '{64'h10, 64, 1, '{64, 0, 0, 0}, 8'h20, 0, 18'd0};
    vt[5] = '{64'hFF_FFC0, 128, 2, '{64, 64, 0, 0}, 8'h20, 0, 18'd0};
    vt[6] = '{64'hFF_FFC0, 64, 1, '{64, 0, 0, 0}, 8'h80, 1, 18'h3FFFF};
    vt[7] = '{64'h80, 100, 2, '{64, 64, 0, 0}, 8'h10, 2, 18'd2};

    aresetn       = 1'b0;
    s_cmd_valid   = 1'b0;
    s_cmd_address = '0;
    s_cmd_length  = '0;
    s_data_valid  = 1'b0;
    s_data_data   = '0;
    s_data_keep   = '0;
    s_data_last   = 1'b0;
    m_sts_ready   = 1'b1;

    repeat (3) @(posedge clk);
    #2;
    check("rst_cmd_ready", 64'(s_cmd_ready), 64'd0);
    check("rst_data_ready", 64'(s_data_ready), 64'd0);
    check("rst_sts_valid", 64'(m_sts_valid), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_cmd_cnt", 64'(cmd_cnt), 64'd0);
    aresetn = 1'b1;
    @(posedge clk);
    #2;
    check("idle_cmd_ready", 64'(s_cmd_ready), 64'd1);

    for (int v = 0; v < 8; v++) begin
      clear_q();
      for (int b = 0; b < 4; b++) drv_nb[b] = vt[v].nb[b];
      for (int i = 0; i < vt[v].nw; i++) exp_widx.push_back(i);
      run_txn(vt[v].addr, vt[v].len, vt[v].nbeats, 1'b0);
      compare($sformatf("vec%0d", v), vt[v].sts, vt[v].a0);
      if (v == 0) check_cnts("vec0");
    end
    check_cnts("table");

    // Zero-length command: status straight away, held while not accepted.
    clear_q();
    m_sts_ready = 1'b0;
    send_cmd(64'h0, 0);
    exp_cmd++;
    @(negedge clk);
    check("len0_sts_valid", 64'(m_sts_valid), 64'd1);
    check("len0_sts_data", 64'(m_sts_data), 64'h80);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!m_sts_valid || m_sts_data != 8'h80 || s_cmd_ready || s_data_ready)
        stable = 1'b0;
    end
    check("len0_hold_stable", 64'(stable), 64'd1);
    @(posedge clk);
    #2;
    wait_sts();
    exp_sts++;
    check("len0_nsts", 64'(sts_q.size()), 64'd1);
    if (sts_q.size() > 0) check("len0_sts", 64'(sts_q[0]), 64'h80);
    check_cnts("len0");

    // Randomized traffic against the model.
    for (int t = 0; t < 60; t++) begin
      logic [63:0] a;
      int len;
      int nbeats;
      int left;
      int r;
      clear_q();
      r = int'($urandom % 8);
      if (r == 0) a = 64'($urandom % 32'h100_0000);
      else if (r == 1) a = 64'h100_0000 - 64'(64 * ($urandom_range(1, 4)));
      else if (r == 2) a = 64'hFFFF_FFFF_FFFF_FFC0;
      else a = 64'($urandom % 32'h4_0000) * 64;
      len = ($urandom % 8 == 0) ? 0 : int'($urandom_range(1, 320));
      if (len == 0) begin
        nbeats = 0;
      end else begin
        nbeats = (len + 63) / 64 + int'($urandom % 3) - 1;
        if (nbeats < 1) nbeats = 1;
      end
      left = len;
      for (int b = 0; b < nbeats; b++) begin
        if ($urandom % 4 == 0) drv_nb[b] = int'($urandom_range(0, 64));
        else if (left == 0 || left >= 64) drv_nb[b] = 64;
        else drv_nb[b] = left;
        left = (left > drv_nb[b]) ? left - drv_nb[b] : 0;
      end
      model(a, len, nbeats, msts);
      run_txn(a, len, nbeats, 1'b1);
      compare($sformatf("rnd%0d", t), msts, a[23:6]);
    end
    check_cnts("random");

    // Reset during a transfer drops it without a status.
    clear_q();
    send_cmd(64'h0, 128);
    send_beat(rnd_data(), '1, 1'b0);
    aresetn = 1'b0;
    #1;
    check("mid_rst_mem_we", 64'(mem_we), 64'd0);
    check("mid_rst_data_ready", 64'(s_data_ready), 64'd0);
    check("mid_rst_cmd_ready", 64'(s_cmd_ready), 64'd0);
    check("mid_rst_sts_valid", 64'(m_sts_valid), 64'd0);
    check("mid_rst_cmd_cnt", 64'(cmd_cnt), 64'd0);
    check("mid_rst_last_cnt", 64'(last_cnt), 64'd0);
    repeat (3) @(posedge clk);
    #2;
    aresetn  = 1'b1;
    exp_cmd  = 0;
    exp_last = 0;
    exp_sts  = 0;
    @(posedge clk);
    #2;
    clear_q();
    drv_nb[0] = 64;
    exp_widx.push_back(0);
    run_txn(64'h0, 64, 1, 1'b0);
    compare("post_rst", 8'h80, 18'd0);
    check_cnts("post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
